// File: rtl/snn_seq_pkg.sv
// Shared types and widths for the SNN run sequencer.
package snn_seq_pkg;

  localparam int FRAME_W = 8;
  localparam int STEP_W  = 5;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_WAIT_RDY,
    S_CAPTURE,
    S_DONE
  } state_t;

  // 00 = no spikes, 01 = neuron 0 wins, 10 = neuron 1 wins, 11 = tie
  function automatic logic [1:0] winner_code(input logic [CNT_W-1:0] c0,
                                             input logic [CNT_W-1:0] c1);
    if (c0 == '0 && c1 == '0) return 2'b00;
    else if (c0 > c1)         return 2'b01;
    else if (c1 > c0)         return 2'b10;
    else                      return 2'b11;
  endfunction

endpackage

// File: rtl/snn_seq_spike_counter.sv
// Saturating spike counters for output neurons 0/1 plus winner decision.
module snn_seq_spike_counter
  import snn_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_capture,
  input  logic [1:0]       i_spikes,
  input  logic             i_latch,
  output logic [CNT_W-1:0] o_count0,
  output logic [CNT_W-1:0] o_count1,
  output logic [1:0]       o_winner
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count [2];
  logic [1:0]       r_winner;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset || i_clear)
          r_count[gi] <= '0;
        else if (i_capture && i_spikes[gi] && r_count[gi] != CNT_MAX)
          r_count[gi] <= r_count[gi] + CNT_W'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      r_winner <= 2'b00;
    else if (i_latch)
      r_winner <= winner_code(r_count[0], r_count[1]);
  end

  assign o_count0 = r_count[0];
  assign o_count1 = r_count[1];
  assign o_winner = r_winner;

endmodule

// File: rtl/snn_sequencer.sv
// Steps a spiking network through num_steps frames: fetch, settle, wait, capture.
// Optional spike counters/winner outputs enabled by SNN_SEQ_SPIKE_COUNT_EN.
module snn_sequencer
  import snn_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [STEP_W-1:0]  num_steps,
  input  logic               in_valid,
  input  logic [FRAME_W-1:0] in_spikes,
  output logic               in_ready,
  output logic               net_enable,
  output logic               net_delay_clk,
  output logic [FRAME_W-1:0] net_input_spikes,
  input  logic [FRAME_W-1:0] net_output_spikes,
  input  logic               net_data_ready,
  output logic               out_valid,
  output logic [FRAME_W-1:0] out_spikes,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
`ifdef SNN_SEQ_SPIKE_COUNT_EN
  ,
  output logic [CNT_W-1:0]   count0,
  output logic [CNT_W-1:0]   count1,
  output logic [1:0]         winner
`endif
);

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t             r_state, w_state_next;
  logic [7:0]         r_tmr;
  logic [STEP_W-1:0]  r_num, r_step;
  logic [FRAME_W-1:0] r_net_in, r_out_spikes;
  logic               r_in_ready, r_net_en, r_delay_clk, r_out_valid;
  logic               r_busy, r_done, r_timeout_err;
  logic               w_accept, w_fetch_xfer, w_timeout, w_capture, w_done_fire;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_fetch_xfer = 1'b0;
    w_timeout    = 1'b0;
    w_capture    = 1'b0;
    w_done_fire  = 1'b0;
    case (r_state)
      S_IDLE: if (start && num_steps != '0) begin
        w_state_next = S_FETCH;
        w_accept     = 1'b1;
      end
      S_FETCH: if (in_valid && r_in_ready) begin
        w_state_next = S_RUN;
        w_fetch_xfer = 1'b1;
      end
      S_RUN: if (r_tmr == SETTLE_LAST) w_state_next = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (net_data_ready) begin
          w_state_next = S_CAPTURE;
        end else if (r_tmr == TIMEOUT_LAST) begin
          w_state_next = S_CAPTURE;
          w_timeout    = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_capture    = 1'b1;
        w_state_next = (r_step + STEP_W'(1) == r_num) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_done_fire  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Abort wins over every action, including a pending capture.
    if (abort && r_state != S_IDLE) begin
      w_state_next = S_IDLE;
      w_fetch_xfer = 1'b0;
      w_timeout    = 1'b0;
      w_capture    = 1'b0;
      w_done_fire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr         <= '0;
      r_num         <= '0;
      r_step        <= '0;
      r_net_in      <= '0;
      r_out_spikes  <= '0;
      r_in_ready    <= 1'b0;
      r_net_en      <= 1'b0;
      r_delay_clk   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tmr <= (w_state_next != r_state) ? 8'd0 : r_tmr + 8'd1;
      if (w_accept) begin
        r_num         <= num_steps;
        r_step        <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_timeout)    r_timeout_err <= 1'b1;
      if (w_fetch_xfer) r_net_in <= in_spikes;
      if (w_done_fire)  r_net_in <= '0;
      if (w_capture) begin
        r_out_spikes <= net_output_spikes;
        r_step       <= r_step + STEP_W'(1);
      end
      r_out_valid <= w_capture;
      r_delay_clk <= w_capture;
      r_done      <= w_done_fire;
      r_in_ready  <= (w_state_next == S_FETCH);
      r_net_en    <= (w_state_next == S_RUN) || (w_state_next == S_WAIT_RDY);
      r_busy      <= (w_state_next != S_IDLE);
    end
  end

  assign in_ready         = r_in_ready;
  assign net_enable       = r_net_en;
  assign net_delay_clk    = r_delay_clk;
  assign net_input_spikes = r_net_in;
  assign out_valid        = r_out_valid;
  assign out_spikes       = r_out_spikes;
  assign busy             = r_busy;
  assign done             = r_done;
  assign timeout_err      = r_timeout_err;

`ifdef SNN_SEQ_SPIKE_COUNT_EN
  snn_seq_spike_counter u_spike_counter (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_capture (w_capture),
    .i_spikes  (net_output_spikes[1:0]),
    .i_latch   (w_done_fire),
    .o_count0  (count0),
    .o_count1  (count1),
    .o_winner  (winner)
  );
`endif

endmodule

// File: doc/snn_sequencer.md
SNN_SEQUENCER -- requirements
Module: snn_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles net_enable is held before net_data_ready is sampled (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 63: maximum cycles spent in WAIT_RDY (legal range 1..255).
REQ-003 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous, active-high.
REQ-004 SHALL have ports: start input 1, begin a run; abort input 1, cancel a run; num_steps input 5, timesteps per run.
REQ-005 SHALL have ports: in_valid input 1, in_spikes input 8 (input frame), in_ready output 1.
REQ-006 SHALL have ports: net_enable output 1; net_delay_clk output 1; net_input_spikes output 8; net_output_spikes input 8; net_data_ready input 1.
REQ-007 SHALL have ports: out_valid output 1; out_spikes output 8; busy output 1; done output 1; timeout_err output 1.

Function
REQ-008 SHALL implement the states IDLE, FETCH, RUN, WAIT_RDY, CAPTURE and DONE, with every output driven from registers.
REQ-009 IDLE: on start=1 with num_steps!=0, SHALL latch num_steps, clear the step counter and timeout_err, and go to FETCH; start with num_steps=0 SHALL be ignored.
REQ-010 FETCH: SHALL assert in_ready=1; on in_valid&&in_ready it SHALL register in_spikes into net_input_spikes and go to RUN (one transfer per timestep).
REQ-011 RUN: SHALL assert net_enable=1 for exactly SETTLE_CYCLES cycles, then go to WAIT_RDY.
REQ-012 WAIT_RDY: SHALL hold net_enable=1 and go to CAPTURE on net_data_ready=1; after TIMEOUT_CYCLES cycles without it, SHALL set sticky timeout_err=1 and go to CAPTURE.
REQ-013 CAPTURE (one cycle): SHALL register net_output_spikes into out_spikes and pulse out_valid=1 and net_delay_clk=1 for one cycle, drop net_enable, and increment the step counter.
REQ-014 After CAPTURE, SHALL go to DONE if the step counter equals the latched num_steps, otherwise to FETCH.
REQ-015 DONE: SHALL pulse done=1 for one cycle, clear net_input_spikes to 0, and return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE; start while busy=1 SHALL be ignored.
REQ-017 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge with net_enable=0 and in_ready=0, and SHALL NOT pulse done; abort has priority over every other transition, including CAPTURE.
REQ-018 Run latency for T steps with immediate in_valid and net_data_ready: done pulses exactly T*(SETTLE_CYCLES+3)+1 cycles after the start edge.
REQ-019 A new run SHALL be accepted on the cycle after done is pulsed.

Reset
REQ-020 On reset=1 at a clk edge, SHALL enter IDLE and clear all outputs to 0, including out_spikes, net_input_spikes and timeout_err.
REQ-021 reset SHALL override abort and start in the same cycle.

Configuration
REQ-022 With SNN_SEQ_SPIKE_COUNT_EN defined, SHALL add outputs count0 (5 bits), count1 (5 bits) and winner (2 bits).
REQ-023 Under SNN_SEQ_SPIKE_COUNT_EN, in CAPTURE count0 and count1 SHALL increment, saturating at 31, when net_output_spikes[0] or net_output_spikes[1] respectively is set; both SHALL clear on accepted start and on reset.
REQ-024 Under SNN_SEQ_SPIKE_COUNT_EN, winner SHALL be updated in DONE: 00 = both counts 0, 01 = count0>count1, 10 = count1>count0, 11 = equal and nonzero.
REQ-025 Without SNN_SEQ_SPIKE_COUNT_EN, these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 Package snn_seq_pkg SHALL hold the state enum, the frame width (8), the step-counter width (5) and the spike-count width (5).
REQ-027 The spike counters and winner logic SHALL form the sub-module snn_seq_spike_counter, instantiated only under SNN_SEQ_SPIKE_COUNT_EN.

Verification
REQ-028 num_steps=3, frames 0x81/0x42/0x24, net_data_ready tied to 1 -> three out_valid pulses, three net_delay_clk pulses, done at cycle 22 after start (SETTLE_CYCLES=4).
REQ-029 num_steps=2, net_data_ready held at 0 -> WAIT_RDY lasts 63 cycles per step, timeout_err=1, done still pulses once.
REQ-030 abort asserted in the third RUN cycle of step 2 -> IDLE next cycle, net_enable=0, no done; then start with num_steps=1 completes normally.
REQ-031 start with num_steps=0, and start pulsed while busy -> no state change and the current run is unaffected.
REQ-032 SNN_SEQ_SPIKE_COUNT_EN defined, num_steps=5, net_output_spikes[1:0] pattern 01,11,10,10,00 -> count0=2, count1=3, winner=10.
REQ-033 reset asserted in CAPTURE together with abort -> all outputs 0 on the next cycle and no out_valid pulse.
